// File: rtl/ex_pkg.sv
// Shared types and exception codes for the exception/ERTN redirect sequencer.
package ex_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_EXC,
    K_INT,
    K_ERTN
  } kind_t;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  // Interrupt outranks an exception, which outranks ERTN.
  function automatic kind_t sel_kind(input logic intp, input logic ex, input logic ertn);
    if (intp)      return K_INT;
    else if (ex)   return K_EXC;
    else if (ertn) return K_ERTN;
    else           return K_NONE;
  endfunction

endpackage

// File: rtl/exc_stat_cnt.sv
// Saturating 32-bit event counters for taken exceptions/interrupts and ERTNs.
module exc_stat_cnt (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_inc_exc,
  input  logic        i_inc_ertn,
  output logic [31:0] o_exc_count,
  output logic [31:0] o_ertn_count
);

  logic [31:0] r_exc_count;
  logic [31:0] r_ertn_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exc_count  <= '0;
      r_ertn_count <= '0;
    end else begin
      if (i_inc_exc && (r_exc_count != '1))
        r_exc_count <= r_exc_count + 32'd1;
      if (i_inc_ertn && (r_ertn_count != '1))
        r_ertn_count <= r_ertn_count + 32'd1;
    end
  end

  assign o_exc_count  = r_exc_count;
  assign o_ertn_count = r_ertn_count;

endmodule

// File: rtl/ex_redirect_ctrl.sv
// Exception/ERTN sequencer: cancel at WB, CSR commit pulse, flush, then IF redirect.
// Define EXC_STAT_EN to enable the saturating exc_count/ertn_count statistics.
module ex_redirect_ctrl
  import ex_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid,
  input  logic            wb_ex,
  input  logic [5:0]      wb_ecode,
  input  logic [8:0]      wb_esubcode,
  input  logic            wb_ertn,
  input  logic [PC_W-1:0] wb_pc,
  input  logic            int_pending,
  input  logic [PC_W-1:0] csr_eentry,
  input  logic [PC_W-1:0] csr_era,
  output logic            wb_cancel,
  output logic            csr_ex_commit,
  output logic [5:0]      csr_ex_ecode,
  output logic [8:0]      csr_ex_esubcode,
  output logic [PC_W-1:0] csr_ex_pc,
  output logic            csr_ertn_commit,
  output logic            pipe_flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy,
  output logic [31:0]     exc_count,
  output logic [31:0]     ertn_count
);

  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_t          r_state;
  kind_t           r_kind;
  logic [5:0]      r_ecode;
  logic [8:0]      r_subcode;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_target;
  logic [3:0]      r_cnt;
  logic            r_ex_commit;
  logic            r_ertn_commit;
  logic            r_flush;
  logic            r_rvalid;
  logic            r_busy;

  logic            w_trigger;
  kind_t           w_kind;

  always_comb begin
    w_kind    = sel_kind(int_pending, wb_ex, wb_ertn);
    w_trigger = wb_valid & (int_pending | wb_ex | wb_ertn);
  end

  // Gated with resetn so the cancel is also quiet while reset is held.
  assign wb_cancel = resetn & (r_state == S_IDLE) & w_trigger & (w_kind != K_ERTN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_kind        <= K_NONE;
      r_ecode       <= '0;
      r_subcode     <= '0;
      r_pc          <= '0;
      r_target      <= '0;
      r_cnt         <= '0;
      r_ex_commit   <= 1'b0;
      r_ertn_commit <= 1'b0;
      r_flush       <= 1'b0;
      r_rvalid      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state       <= S_COMMIT;
            r_kind        <= w_kind;
            r_ecode       <= (w_kind == K_EXC) ? wb_ecode : ECODE_INT;
            r_subcode     <= (w_kind == K_EXC) ? wb_esubcode : '0;
            r_pc          <= wb_pc;
            r_ex_commit   <= (w_kind != K_ERTN);
            r_ertn_commit <= (w_kind == K_ERTN);
            r_flush       <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_COMMIT: begin
          r_ex_commit   <= 1'b0;
          r_ertn_commit <= 1'b0;
          r_target      <= (r_kind == K_ERTN) ? csr_era : csr_eentry;
          if (FLUSH_CYCLES > 0) begin
            r_state <= S_FLUSH;
            r_cnt   <= FLUSH_LOAD;
          end else begin
            r_state  <= S_REDIRECT;
            r_rvalid <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_cnt == '0) begin
            r_state  <= S_REDIRECT;
            r_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_state  <= S_IDLE;
            r_rvalid <= 1'b0;
            r_flush  <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign csr_ex_commit   = r_ex_commit;
  assign csr_ertn_commit = r_ertn_commit;
  assign csr_ex_ecode    = r_ecode;
  assign csr_ex_esubcode = r_subcode;
  assign csr_ex_pc       = r_pc;
  assign pipe_flush      = r_flush;
  assign redirect_valid  = r_rvalid;
  assign redirect_pc     = r_target;
  assign busy            = r_busy;

`ifdef EXC_STAT_EN
  exc_stat_cnt u_stat (
    .clk          (clk),
    .resetn       (resetn),
    .i_inc_exc    (r_ex_commit),
    .i_inc_ertn   (r_ertn_commit),
    .o_exc_count  (exc_count),
    .o_ertn_count (ertn_count)
  );
`else
  assign exc_count  = '0;
  assign ertn_count = '0;
`endif

endmodule
